mips_mem_loader: RTL and testbench
==================================

# mips_mem_loader

Boot-time program loader and memory-port owner for the multi-cycle MIPS core. It holds the core in reset and accepts a byte stream from a host over a valid/ready handshake. It packs the bytes little-endian into 32-bit words and writes them to consecutive word addresses of the unified instruction/data memory. After the last word it hands the memory port to the core and releases the core's reset.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width; must be a multiple of 8.
- ADDR_WIDTH, 10, memory word-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request.
- len  in  ADDR_WIDTH+1  number of words to load; sampled on an accepted start.
- s_valid  in  1  host byte valid.
- s_data  in  8  host byte.
- s_ready  out  1  loader accepts a byte this cycle.
- core_addr  in  ADDR_WIDTH  core memory address.
- core_wr_data  in  DATA_WIDTH  core write data.
- core_wr_en  in  1  core write enable.
- mem_addr  out  ADDR_WIDTH  to memory.
- mem_wr_data  out  DATA_WIDTH  to memory.
- mem_wr_en  out  1  to memory.
- core_rst_n  out  1  active-low reset to the core; 0 holds the core.
- busy  out  1  in LOAD or WRITE.
- done  out  1  in RUN.

## Operation
- FSM states: IDLE, LOAD, WRITE, RUN.
- Reset values: state IDLE, core_rst_n=0, s_ready=0, busy=0, done=0, mem_wr_en=0, word index 0, byte index 0.
- IDLE
  - start=1 with len=0 → RUN.
  - start=1 with len>0 → LOAD. Latch eff_len = min(len, 2**ADDR_WIDTH) and clear both indices.
- LOAD: s_ready=1.
  - Each cycle with s_valid&s_ready stores s_data into byte lane byte_idx, where lane 0 is bits [7:0]. byte_idx then increments.
  - Accepting lane DATA_WIDTH/8-1 → WRITE, and byte_idx wraps to 0.
- WRITE: s_ready=0. Exactly one cycle with mem_wr_en=1, mem_addr=word_idx, mem_wr_data=assembled word.
  - If word_idx==eff_len-1 → RUN.
  - Otherwise word_idx+1 and → LOAD.
- RUN: the memory port is a pure combinational pass-through of core_addr, core_wr_data and core_wr_en. core_rst_n=1 and done=1.
  - start=1 in RUN re-enters the load sequence exactly as from IDLE, including the len=0 case: RUN → RUN.
- Outside RUN, core inputs are ignored. mem_addr=word_idx, mem_wr_data=assembled word, and mem_wr_en=0 except in WRITE.
- start is ignored in LOAD and WRITE. There is no abort; only rst cancels a load.
- rst mid-load: the partial word is discarded and the FSM returns to IDLE with core_rst_n=0. Words already written stay in memory.
- Host stalls (s_valid=0) may be any length. No byte is lost or duplicated.

## Timing
- busy, done and core_rst_n are registered state decodes. They change on the first cycle of the new state.
- s_ready is a combinational decode of state, registered-state only. There is no combinational path from s_valid.
- Load latency: start → first LOAD cycle is 1 cycle.
- N words at full host rate take 4N+N cycles from the first LOAD cycle to the first RUN cycle.
- core_rst_n rises in the first RUN cycle. The core's first fetch is the following cycle, at address 0.
- RUN→LOAD on start drops core_rst_n in the next cycle. Core writes issued in that start cycle still pass through.
- word_idx never wraps. eff_len ≤ 2**ADDR_WIDTH ensures the last write is address 2**ADDR_WIDTH-1.

## Structure
- MIPS_pkg gains:
  - loader_state_e, with IDLE/LOAD/WRITE/RUN in 2 bits.
  - MIPS_LOADER_BYTES = MIPS_DATA_WIDTH/8.
- One sub-module: byte_packer (DATA_WIDTH). It has clear, byte-write enable, byte data, a lane index, word out, and a last-lane flag.
- The memory output mux reuses the existing mux_param with NUM_INPUTS=2, selected by state==RUN.

## Test plan
- Reset then start with len=2 and bytes 11,22,33,44,55,66,77,88 at full rate → writes 0x44332211 @0 and 0x88776655 @1. RUN is reached 10 cycles after the first LOAD cycle; core_rst_n goes 0→1 then.
- Same load with s_valid toggling 1/0 → identical writes. Exactly two mem_wr_en pulses, and s_ready=0 during each WRITE.
- start with len=0 → RUN next cycle, no mem_wr_en, core_rst_n=1. In RUN, core_wr_en=1, core_addr=5, data 0xDEADBEEF → appears on the mem port the same cycle.
- ADDR_WIDTH=2, len=7 → exactly 4 writes to addresses 0..3, then RUN.
- rst asserted after 6 bytes of a len=3 load → IDLE, core_rst_n=0, only the word @0 written. A fresh start reloads from address 0 and from byte lane 0.
- In RUN, start with len=1 → core_rst_n=0 next cycle and core inputs ignored. The word is written @0, then RUN again with core_rst_n=1. A start pulsed during LOAD has no effect.

Source files
------------

// File: rtl/mips_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_loader_pkg
//  Description : Shared types and constants for the MIPS boot-time loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_loader_pkg;

    localparam int MIPS_DATA_WIDTH   = 32;
    localparam int MIPS_LOADER_BYTES = MIPS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } loader_state_e;

    // Registered status outputs implied by a state: {busy, done, core_rst_n}
    function automatic logic [2:0] loader_flags(input loader_state_e s);
        logic [2:0] f;
        f = 3'b000;
        case (s)
            LOAD, WRITE: f = 3'b100;
            RUN:         f = 3'b011;
            default:     f = 3'b000;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_loader_byte_packer
//  Description : Assembles host bytes into a little-endian memory word.
//                Lane 0 occupies bits [7:0].
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_loader_byte_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_W     = ((DATA_WIDTH / 8) > 1) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_wr_en,
    input  logic [7:0]            i_data,
    input  logic [LANE_W-1:0]     i_lane,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_last_lane
);

    localparam int c_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_word;

    // Store the incoming byte into the addressed lane; clear drops any partial word
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_word <= '0;
        end else if (i_wr_en) begin
            for (int k = 0; k < c_BYTES; k++) begin
                if (i_lane == LANE_W'(k)) begin
                    r_word[8*k +: 8] <= i_data;
                end
            end
        end
    end

    assign o_word      = r_word;
    assign o_last_lane = (i_lane == LANE_W'(c_BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/mux_param.sv
`default_nettype none
// ============================================================================
//  Module      : mux_param
//  Description : Generic N-input combinational multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_param #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 2,
    parameter int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]                 i_sel,
    output logic [WIDTH-1:0]                 o_data
);

    // Select one input; out-of-range selects read as zero
    always_comb begin
        o_data = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_data[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_loader
//  Description : Boot loader and memory-port owner. Holds the core in reset,
//                streams host bytes into memory as little-endian words, then
//                hands the memory port to the core and releases its reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wr_data,
    input  logic                  core_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done
);

    import mips_mem_loader_pkg::*;

    localparam int c_BYTES  = DATA_WIDTH / 8;
    localparam int c_LANE_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam int c_MUX_W  = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] c_MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    loader_state_e         r_state;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [c_LANE_W-1:0]   r_byte_idx;
    logic [ADDR_WIDTH:0]   r_eff_len;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_core_rst_n;

    logic                  w_accept;
    logic                  w_idle_or_run;
    logic                  w_clear;
    logic                  w_last_lane;
    logic                  w_last_word;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_run;
    logic [1:0][c_MUX_W-1:0] w_mux_in;
    logic [c_MUX_W-1:0]    w_mux_out;

    assign s_ready       = (r_state == LOAD);
    assign w_accept      = s_ready && s_valid;
    assign w_idle_or_run = (r_state == IDLE) || (r_state == RUN);
    assign w_clear       = w_idle_or_run && start && (len != '0);
    assign w_last_word   = ({1'b0, r_word_idx} == (r_eff_len - (ADDR_WIDTH+1)'(1)));
    assign w_run         = (r_state == RUN);

    mips_mem_loader_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_wr_en     (w_accept),
        .i_data      (s_data),
        .i_lane      (r_byte_idx),
        .o_word      (w_word),
        .o_last_lane (w_last_lane)
    );

    // Loader FSM; status outputs are registered alongside the state they decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_eff_len  <= '0;
            {r_busy, r_done, r_core_rst_n} <= loader_flags(IDLE);
        end else begin
            case (r_state)
                IDLE, RUN: begin
                    if (start) begin
                        if (len == '0) begin
                            r_state <= RUN;
                            {r_busy, r_done, r_core_rst_n} <= loader_flags(RUN);
                        end else begin
                            r_state    <= LOAD;
                            r_eff_len  <= len[ADDR_WIDTH] ? c_MAX_LEN : len;
                            r_word_idx <= '0;
                            r_byte_idx <= '0;
                            {r_busy, r_done, r_core_rst_n} <= loader_flags(LOAD);
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        if (w_last_lane) begin
                            r_byte_idx <= '0;
                            r_state    <= WRITE;
                            {r_busy, r_done, r_core_rst_n} <= loader_flags(WRITE);
                        end else begin
                            r_byte_idx <= r_byte_idx + c_LANE_W'(1);
                        end
                    end
                end
                WRITE: begin
                    // Last word index is eff_len-1, so word_idx never wraps
                    if (w_last_word) begin
                        r_state <= RUN;
                        {r_busy, r_done, r_core_rst_n} <= loader_flags(RUN);
                    end else begin
                        r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
                        r_state    <= LOAD;
                        {r_busy, r_done, r_core_rst_n} <= loader_flags(LOAD);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    {r_busy, r_done, r_core_rst_n} <= loader_flags(IDLE);
                end
            endcase
        end
    end

    // Memory port: loader drives it until RUN, then the core owns it combinationally
    assign w_mux_in[0] = {r_word_idx, w_word, (r_state == WRITE)};
    assign w_mux_in[1] = {core_addr, core_wr_data, core_wr_en};

    mux_param #(
        .WIDTH      (c_MUX_W),
        .NUM_INPUTS (2)
    ) u_mem_mux (
        .i_data (w_mux_in),
        .i_sel  (w_run),
        .o_data (w_mux_out)
    );

    assign {mem_addr, mem_wr_data, mem_wr_en} = w_mux_out;

    assign busy       = r_busy;
    assign done       = r_done;
    assign core_rst_n = r_core_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_mem_loader
//  Description : Directed self-checking bench for mips_mem_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (ADDR_WIDTH=10)
    logic        rst, start, s_valid, s_ready;
    logic [10:0] len;
    logic [7:0]  s_data;
    logic [9:0]  core_addr, mem_addr;
    logic [31:0] core_wr_data, mem_wr_data;
    logic        core_wr_en, mem_wr_en, core_rst_n, busy, done;

    // Small instance (ADDR_WIDTH=2)
    logic        start_s, s_valid_s, s_ready_s;
    logic [2:0]  len_s;
    logic [7:0]  s_data_s;
    logic [1:0]  core_addr_s, mem_addr_s;
    logic [31:0] core_wr_data_s, mem_wr_data_s;
    logic        core_wr_en_s, mem_wr_en_s, core_rst_n_s, busy_s, done_s;

    mips_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .core_addr(core_addr), .core_wr_data(core_wr_data), .core_wr_en(core_wr_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .core_rst_n(core_rst_n), .busy(busy), .done(done)
    );

    mips_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .len(len_s),
        .s_valid(s_valid_s), .s_data(s_data_s), .s_ready(s_ready_s),
        .core_addr(core_addr_s), .core_wr_data(core_wr_data_s), .core_wr_en(core_wr_en_s),
        .mem_addr(mem_addr_s), .mem_wr_data(mem_wr_data_s), .mem_wr_en(mem_wr_en_s),
        .core_rst_n(core_rst_n_s), .busy(busy_s), .done(done_s)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_in_write = 0;

    logic [9:0]  wa[$];
    logic [31:0] wd[$];
    logic [1:0]  wa_s[$];
    logic [31:0] wd_s[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every loader-issued write (core pass-through writes only occur with done=1)
    always @(negedge clk) begin
        if (mem_wr_en && !done) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wr_data);
            if (s_ready) ready_in_write++;
        end
        if (mem_wr_en_s && !done_s) begin
            wa_s.push_back(mem_addr_s);
            wd_s.push_back(mem_wr_data_s);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("send_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic send_s(input logic [7:0] b);
        int n;
        n = 0;
        s_valid_s = 1'b1;
        s_data_s  = b;
        while (!s_ready_s && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("send_s_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
    endtask

    logic [7:0]  bytes_a [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [31:0] words_s [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

    initial begin
        int base, base_s, t0, rw0;
        rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
        core_addr = '0; core_wr_data = '0; core_wr_en = 1'b0;
        start_s = 1'b0; len_s = '0; s_valid_s = 1'b0; s_data_s = '0;
        core_addr_s = '0; core_wr_data_s = '0; core_wr_en_s = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_s_ready",    s_ready,    0);
        check("rst_busy",       busy,       0);
        check("rst_done",       done,       0);
        check("rst_mem_wr_en",  mem_wr_en,  0);
        check("rst_small_done", done_s,     0);

        // Full-rate load of two words
        base = wa.size();
        start = 1'b1; len = 11'd2;
        tick();
        start = 1'b0;
        t0 = cyc;
        check("load_busy",    busy,    1);
        check("load_s_ready", s_ready, 1);
        for (int i = 0; i < 8; i++) send(bytes_a[i]);
        s_valid = 1'b0;
        check("write_en",        mem_wr_en,   1);
        check("write_s_ready",   s_ready,     0);
        check("write_addr",      mem_addr,    1);
        check("write_data",      mem_wr_data, 32'h88776655);
        check("write_core_rst",  core_rst_n,  0);
        wait_done();
        check("run_latency",  cyc - t0,   10);
        check("run_done",     done,       1);
        check("run_core_rst", core_rst_n, 1);
        check("run_busy",     busy,       0);
        check("fr_count",     wa.size() - base, 2);
        check("fr_addr0",     wa[base],     0);
        check("fr_data0",     wd[base],     32'h44332211);
        check("fr_addr1",     wa[base+1],   1);
        check("fr_data1",     wd[base+1],   32'h88776655);

        // Same load with a host stall after every byte
        rst = 1'b1; tick(); rst = 1'b0;
        base = wa.size();
        rw0  = ready_in_write;
        start = 1'b1; len = 11'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(bytes_a[i]);
            s_valid = 1'b0;
            tick();
        end
        wait_done();
        check("st_done",       done, 1);
        check("st_count",      wa.size() - base, 2);
        check("st_data0",      wd[base],   32'h44332211);
        check("st_addr1",      wa[base+1], 1);
        check("st_data1",      wd[base+1], 32'h88776655);
        check("st_ready_in_wr", ready_in_write - rw0, 0);

        // len=0 goes straight to RUN; core owns the memory port
        rst = 1'b1; tick(); rst = 1'b0;
        base = wa.size();
        start = 1'b1; len = 11'd0;
        tick();
        start = 1'b0;
        check("z_done",     done,       1);
        check("z_core_rst", core_rst_n, 1);
        check("z_busy",     busy,       0);
        check("z_s_ready",  s_ready,    0);
        core_wr_en = 1'b1; core_addr = 10'd5; core_wr_data = 32'hDEADBEEF;
        #1;
        check("pt_wr_en", mem_wr_en,   1);
        check("pt_addr",  mem_addr,    5);
        check("pt_data",  mem_wr_data, 32'hDEADBEEF);
        core_wr_en = 1'b0; core_addr = '0; core_wr_data = '0;
        tick();
        check("z_no_writes", wa.size() - base, 0);

        // ADDR_WIDTH=2 with len=7 clamps to four words
        base_s = wa_s.size();
        start_s = 1'b1; len_s = 3'd7;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < 16; i++) send_s(8'(i));
        s_valid_s = 1'b0;
        for (int n = 0; n < 60 && !done_s; n++) tick();
        tick(); tick(); tick();
        check("sm_done",  done_s, 1);
        check("sm_busy",  busy_s, 0);
        check("sm_count", wa_s.size() - base_s, 4);
        for (int k = 0; k < 4; k++) begin
            if (wa_s.size() - base_s > k) begin
                check("sm_addr", wa_s[base_s+k], 64'(k));
                check("sm_data", wd_s[base_s+k], words_s[k]);
            end
        end

        // Reset in the middle of the second word of a three-word load
        rst = 1'b1; tick(); rst = 1'b0;
        base = wa.size();
        start = 1'b1; len = 11'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) send(8'hAA + 8'(i));
        s_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("mr_busy",     busy,       0);
        check("mr_done",     done,       0);
        check("mr_core_rst", core_rst_n, 0);
        check("mr_s_ready",  s_ready,    0);
        check("mr_count",    wa.size() - base, 1);
        check("mr_addr0",    wa[base], 0);
        check("mr_data0",    wd[base], 32'hADACABAA);
        base = wa.size();
        start = 1'b1; len = 11'd1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h01 + 8'(i));
        s_valid = 1'b0;
        wait_done();
        check("rl_count",    wa.size() - base, 1);
        check("rl_addr0",    wa[base], 0);
        check("rl_data0",    wd[base], 32'h04030201);
        check("rl_core_rst", core_rst_n, 1);

        // Reload from RUN; start pulse during LOAD must be ignored
        base = wa.size();
        start = 1'b1; len = 11'd1;
        core_wr_en = 1'b1; core_addr = 10'd7; core_wr_data = 32'h12345678;
        #1;
        check("rr_pt_wr_en", mem_wr_en, 1);
        check("rr_pt_addr",  mem_addr,  7);
        tick();
        start = 1'b0;
        check("rr_core_rst", core_rst_n, 0);
        check("rr_done",     done,       0);
        check("rr_busy",     busy,       1);
        check("rr_ign_en",   mem_wr_en,  0);
        check("rr_ign_addr", mem_addr,   0);
        start = 1'b1; len = 11'd0;
        tick();
        start = 1'b0;
        check("rr_start_ign_busy", busy, 1);
        check("rr_start_ign_done", done, 0);
        core_wr_en = 1'b0; core_addr = '0; core_wr_data = '0;
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i));
        s_valid = 1'b0;
        wait_done();
        check("rr_count",    wa.size() - base, 1);
        check("rr_addr0",    wa[base], 0);
        check("rr_data0",    wd[base], 32'hC3C2C1C0);
        check("rr_core_rst1", core_rst_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
